// File: rtl/led_blink_if.sv
// LED drive bundle for the heartbeat blinker.
// Ports: led (blinker -> board pin), 1 = lit.
interface led_blink_if;
   logic led;

   modport master (output led);
   modport slave  (input  led);
endinterface

// File: rtl/led_blink.sv
// Free-running LED heartbeat: OFF_CYCLES low, ON_CYCLES high, repeating.
// Ports: clk, rst (async, active-low), bus.led (registered LED drive).
// Optional macro LED_PWM_EN dims the on phase to PWM_DUTY/2^PWM_W.
module led_blink #(
   parameter int CNT_W      = 16,
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 4,
   parameter int PWM_W      = 4,
   parameter int PWM_DUTY   = 8
) (
   input  logic        clk,
   input  logic        rst,
   led_blink_if.master bus
);

   localparam longint CNT_SPAN = longint'(1) << CNT_W;

   if (ON_CYCLES < 1 || longint'(ON_CYCLES) > CNT_SPAN) begin : g_bad_on
      $error("led_blink: ON_CYCLES out of range");
   end
   if (OFF_CYCLES < 1 || longint'(OFF_CYCLES) > CNT_SPAN) begin : g_bad_off
      $error("led_blink: OFF_CYCLES out of range");
   end
   if (PWM_W < 1 || PWM_DUTY < 0) begin : g_bad_pwm
      $error("led_blink: PWM_W or PWM_DUTY out of range");
   end

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

   typedef enum logic {
      S_OFF,
      S_ON
   } state_t;

   state_t           state;
   state_t           nxt_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt_cnt;
   logic             led_q;
   logic             pwm_on;

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + CNT_W'(1);
      unique case (state)
         S_OFF: begin
            if (cnt == OFF_LAST) begin
               nxt_state = S_ON;
               nxt_cnt   = '0;
            end
         end
         S_ON: begin
            if (cnt == ON_LAST) begin
               nxt_state = S_OFF;
               nxt_cnt   = '0;
            end
         end
         default: begin
            nxt_state = S_OFF;
            nxt_cnt   = '0;
         end
      endcase
   end

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] nxt_pwm;

   // Free-running window counter; wraps naturally at 2^PWM_W.
   assign nxt_pwm = pwm_cnt + PWM_W'(1);
   // Widened compare so duties >= 2^PWM_W give solid on.
   assign pwm_on  = longint'(nxt_pwm) < longint'(PWM_DUTY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= nxt_pwm;
      end
   end
`else
   assign pwm_on = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_OFF;
         cnt   <= '0;
         led_q <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         led_q <= (nxt_state == S_ON) && pwm_on;
      end
   end

   assign bus.led = led_q;

endmodule

// File: tb/tb_led_blink.sv
// Self-checking bench for led_blink: scoreboard of expected LED levels.
// Covers defaults, 1/1 toggle, 3/5 duty, async mid-phase reset, PWM.
module tb_led_blink;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   k;
   int   ones35;
   bit   count_ones;

   logic q_def[$];
   logic q_tog[$];
   logic q_35[$];
`ifdef LED_PWM_EN
   logic q_pwm[$];
`endif

   led_blink_if if_def ();
   led_blink_if if_tog ();
   led_blink_if if_35 ();
`ifdef LED_PWM_EN
   led_blink_if if_pwm ();
`endif

   led_blink u_def (
      .clk (clk),
      .rst (rst),
      .bus (if_def)
   );

   led_blink #(
      .ON_CYCLES  (1),
      .OFF_CYCLES (1)
   ) u_tog (
      .clk (clk),
      .rst (rst),
      .bus (if_tog)
   );

   led_blink #(
      .ON_CYCLES  (3),
      .OFF_CYCLES (5)
   ) u_35 (
      .clk (clk),
      .rst (rst),
      .bus (if_35)
   );

`ifdef LED_PWM_EN
   led_blink #(
      .ON_CYCLES  (8),
      .OFF_CYCLES (8),
      .PWM_W      (2),
      .PWM_DUTY   (2)
   ) u_pwm (
      .clk (clk),
      .rst (rst),
      .bus (if_pwm)
   );
`endif

   initial clk = 1'b0;
   always #3 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   // Level after edge k of reset release: off phase first, then on phase.
   function automatic logic model(int kk, int on, int off, int pw, int duty);
      logic ph;
      ph = (kk % (on + off)) >= off;
      if (pw > 0) return ph && ((kk % (1 << pw)) < duty);
      return ph;
   endfunction

   task automatic run_edges(int n);
      for (int i = 0; i < n; i++) begin
         k++;
         q_def.push_back(model(k, 4, 4, 0, 0));
         q_tog.push_back(model(k, 1, 1, 0, 0));
         q_35.push_back(model(k, 3, 5, 0, 0));
`ifdef LED_PWM_EN
         q_pwm.push_back(model(k, 8, 8, 2, 2));
`endif
         @(posedge clk);
         #1;
         check("def", 32'(if_def.led), 32'(q_def.pop_front()));
         check("tog", 32'(if_tog.led), 32'(q_tog.pop_front()));
         check("d35", 32'(if_35.led), 32'(q_35.pop_front()));
`ifdef LED_PWM_EN
         check("pwm", 32'(if_pwm.led), 32'(q_pwm.pop_front()));
`endif
         if (count_ones && k <= 80 && if_35.led === 1'b1) ones35++;
      end
   endtask

   task automatic check_all_low(string tag);
      check({tag, "_def"}, 32'(if_def.led), 32'd0);
      check({tag, "_tog"}, 32'(if_tog.led), 32'd0);
      check({tag, "_d35"}, 32'(if_35.led), 32'd0);
`ifdef LED_PWM_EN
      check({tag, "_pwm"}, 32'(if_pwm.led), 32'd0);
`endif
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      k          = 0;
      ones35     = 0;
      count_ones = 1'b1;
      rst        = 1'b0;

      #1;
      check_all_low("rst_t1");
      #3;
      check_all_low("rst_t4");
      #6;
      check_all_low("rst_t10");
      rst = 1'b1;

      run_edges(100);
      check("ones35", 32'(ones35), 32'd30);
      count_ones = 1'b0;

      // Edge 100 leaves the default unit mid on-phase.
      check("pre_mid", 32'(if_def.led), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check_all_low("mid_rst");
      #1;
      rst = 1'b1;

      k = 0;
      run_edges(20);

      if (q_def.size() != 0) check("q_left", 32'(q_def.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
